// File: rtl/dma_pkg.sv
// Shared types and constants for the four-channel fly-by DMA controller.
// State encoding, bus-phase codes, register map offsets and mode bit positions.
package dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        S1,
        S2,
        S3,
        REL
    } state_t;

    localparam logic [1:0] AEN_CPU    = 2'b00;
    localparam logic [1:0] AEN_ADDR   = 2'b01;
    localparam logic [1:0] AEN_STROBE = 2'b10;

    localparam logic [1:0] SEL_ADDR_LO = 2'd0;
    localparam logic [1:0] SEL_ADDR_HI = 2'd1;
    localparam logic [1:0] SEL_CNT_LO  = 2'd2;
    localparam logic [1:0] SEL_CNT_HI  = 2'd3;

    localparam logic [4:0] OFF_MODE_BASE  = 5'h10;
    localparam logic [4:0] OFF_MASK       = 5'h14;
    localparam logic [4:0] OFF_CLR_STATUS = 5'h15;

    localparam int MODE_AUTO_INIT = 0;
    localparam int MODE_DEC       = 1;

    localparam int CW = 16;

    // Fixed priority: the lowest-numbered requesting channel wins.
    function automatic logic [1:0] prio_pick(input logic [3:0] req);
        logic [1:0] pick;
        pick = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) pick = 2'(i);
        end
        return pick;
    endfunction

endpackage

// File: rtl/dma_channel.sv
// One DMA channel: base/current address and count, mode bits, terminal-count flag.
// Writes load base and current together; inc advances or auto-reloads the channel.
module dma_channel
    import dma_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [4:0]    wr_off,
    input  logic [DW-1:0] wr_data,
    input  logic          inc,
    output logic [AW-1:0] cur_addr,
    output logic          tc,
    output logic          auto_init
);

    logic [AW-1:0] base_addr_reg;
    logic [AW-1:0] cur_addr_reg;
    logic [CW-1:0] base_cnt_reg;
    logic [CW-1:0] cur_cnt_reg;
    logic [1:0]    mode_reg;

    assign cur_addr  = cur_addr_reg;
    assign tc        = (cur_cnt_reg == '0);
    assign auto_init = mode_reg[MODE_AUTO_INIT];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_addr_reg <= '0;
            cur_addr_reg  <= '0;
            base_cnt_reg  <= '0;
            cur_cnt_reg   <= '0;
            mode_reg      <= '0;
        end else if (wr_en) begin
            if (!wr_off[4]) begin
                case (wr_off[1:0])
                    SEL_ADDR_LO: begin
                        base_addr_reg[DW-1:0] <= wr_data;
                        cur_addr_reg[DW-1:0]  <= wr_data;
                    end
                    SEL_ADDR_HI: begin
                        base_addr_reg[AW-1:DW] <= wr_data;
                        cur_addr_reg[AW-1:DW]  <= wr_data;
                    end
                    SEL_CNT_LO: begin
                        base_cnt_reg[DW-1:0] <= wr_data;
                        cur_cnt_reg[DW-1:0]  <= wr_data;
                    end
                    default: begin
                        base_cnt_reg[CW-1:DW] <= wr_data;
                        cur_cnt_reg[CW-1:DW]  <= wr_data;
                    end
                endcase
            end else begin
                mode_reg <= wr_data[1:0];
            end
        end else if (inc) begin
            if (tc && auto_init) begin
                cur_addr_reg <= base_addr_reg;
                cur_cnt_reg  <= base_cnt_reg;
            end else begin
                cur_addr_reg <= mode_reg[MODE_DEC] ? cur_addr_reg - 1'b1 : cur_addr_reg + 1'b1;
                cur_cnt_reg  <= cur_cnt_reg - 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_controller.sv
// Four-channel fly-by DMA controller: register decode, fixed-priority arbiter,
// bus hold handshake and transfer FSM, mask/status bookkeeping, address driver.
module dma_controller
    import dma_pkg::*;
#(
    parameter int          NCH     = 4,
    parameter int          AW      = 16,
    parameter int          DW      = 8,
    parameter logic [15:0] IO_BASE = 16'h0040
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] DREQ,
    output logic [NCH-1:0] DACK,
    output logic           HRQ,
    input  logic           HLDA,
    output logic [1:0]     AEN,
    inout  wire  [AW-1:0]  address,
    input  logic [DW-1:0]  data,
    input  logic           IOW,
    input  logic           MEM_OR_IO,
    input  logic           demand,
    input  logic           DMA_IN,
    output logic           DIOR,
    output logic           DIOW,
    output logic           DMEMR,
    output logic           DMEMW,
    output logic           EOP,
    output logic [NCH-1:0] STATUS
);

    state_t         state_reg, state_next;
    logic [1:0]     active_ch_reg;
    logic [NCH-1:0] mask_reg;
    logic [NCH-1:0] status_reg;
    logic           iow_prev_reg;

    logic [AW-1:0]  ch_addr [NCH];
    logic [NCH-1:0] ch_tc;
    logic [NCH-1:0] ch_auto;
    logic [NCH-1:0] ch_wr;
    logic [NCH-1:0] eligible;
    logic [4:0]     wr_off;
    logic           wr_hit;
    logic           cur_tc;

    assign wr_off   = address[4:0];
    assign wr_hit   = IOW && !iow_prev_reg && (AEN == AEN_CPU) && !MEM_OR_IO
                      && (address[AW-1:5] == IO_BASE[AW-1:5]);
    assign eligible = DREQ & ~mask_reg;
    assign cur_tc   = ch_tc[active_ch_reg];
    assign STATUS   = status_reg;
    assign address  = (AEN != AEN_CPU) ? ch_addr[active_ch_reg] : {AW{1'bz}};

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            // Channel registers live at 4*ch..4*ch+3, the mode byte at 0x10+ch.
            assign ch_wr[gi] = wr_hit &&
                ((!wr_off[4] && wr_off[3:2] == 2'(gi)) ||
                 (wr_off[4:2] == OFF_MODE_BASE[4:2] && wr_off[1:0] == 2'(gi)));

            dma_channel #(.AW(AW), .DW(DW)) u_channel (
                .clk       (clk),
                .reset     (reset),
                .wr_en     (ch_wr[gi]),
                .wr_off    (wr_off),
                .wr_data   (data),
                .inc       (state_reg == S3 && active_ch_reg == 2'(gi)),
                .cur_addr  (ch_addr[gi]),
                .tc        (ch_tc[gi]),
                .auto_init (ch_auto[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            active_ch_reg <= '0;
            mask_reg      <= '1;
            status_reg    <= '0;
            iow_prev_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            iow_prev_reg <= IOW;
            if (state_reg == IDLE && |eligible)
                active_ch_reg <= prio_pick(eligible);
            if (wr_hit && wr_off == OFF_MASK)
                mask_reg <= data[NCH-1:0];
            if (wr_hit && wr_off == OFF_CLR_STATUS)
                status_reg <= '0;
            // Terminal count: flag it, and retire the channel unless it reloads itself.
            if (state_reg == S3 && cur_tc) begin
                status_reg[active_ch_reg] <= 1'b1;
                if (!ch_auto[active_ch_reg])
                    mask_reg[active_ch_reg] <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (|eligible) state_next = REQ;
            REQ:  if (HLDA) state_next = S1;
            S1:   state_next = S2;
            S2:   state_next = S3;
            S3:   state_next = (demand && DREQ[active_ch_reg] && !cur_tc && HLDA) ? S1 : REL;
            REL:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        HRQ   = 1'b0;
        DACK  = '0;
        AEN   = AEN_CPU;
        DIOR  = 1'b0;
        DIOW  = 1'b0;
        DMEMR = 1'b0;
        DMEMW = 1'b0;
        EOP   = 1'b0;
        case (state_reg)
            REQ: HRQ = 1'b1;
            S1: begin
                HRQ  = 1'b1;
                AEN  = AEN_ADDR;
                DACK = NCH'(1) << active_ch_reg;
            end
            S2: begin
                HRQ   = 1'b1;
                AEN   = AEN_STROBE;
                DACK  = NCH'(1) << active_ch_reg;
                DIOR  = DMA_IN;
                DMEMW = DMA_IN;
                DMEMR = !DMA_IN;
                DIOW  = !DMA_IN;
            end
            S3: begin
                HRQ  = 1'b1;
                AEN  = AEN_STROBE;
                DACK = NCH'(1) << active_ch_reg;
                EOP  = cur_tc;
            end
            default: ;
        endcase
    end

endmodule
